// File: rtl/peak_regfile_mt_if.sv
// Core read/write, context-clear and debug signals of the peak_regfile_mt register file.
// master = core/debug side, slave = register file.
interface peak_regfile_mt_if #(
   parameter int XLEN  = 32,
   parameter int NTASK = 2
);
   localparam int TW = $clog2(NTASK);

   logic [TW-1:0]   WTASKNUM;
   logic [4:0]      WADDR;
   logic            WE;
   logic [XLEN-1:0] WDATA;
   logic [TW-1:0]   RTASKNUM;
   logic [4:0]      RS1ADDR;
   logic [4:0]      RS2ADDR;
   logic [XLEN-1:0] RS1;
   logic [XLEN-1:0] RS2;
   logic            CLR_REQ;
   logic [TW-1:0]   CLR_TASK;
   logic            DBG_REQ;
   logic            DBG_WR;
   logic [TW-1:0]   DBG_TASK;
   logic [4:0]      DBG_AD;
   logic [XLEN-1:0] DBG_DI;
   logic            DBG_ACK;
   logic [XLEN-1:0] DBG_DO;
   logic            DBG_STALL;
   logic            PERR;

   modport master (
      output WTASKNUM, WADDR, WE, WDATA, RTASKNUM, RS1ADDR, RS2ADDR,
      output CLR_REQ, CLR_TASK, DBG_REQ, DBG_WR, DBG_TASK, DBG_AD, DBG_DI,
      input  RS1, RS2, DBG_ACK, DBG_DO, DBG_STALL, PERR
   );

   modport slave (
      input  WTASKNUM, WADDR, WE, WDATA, RTASKNUM, RS1ADDR, RS2ADDR,
      input  CLR_REQ, CLR_TASK, DBG_REQ, DBG_WR, DBG_TASK, DBG_AD, DBG_DI,
      output RS1, RS2, DBG_ACK, DBG_DO, DBG_STALL, PERR
   );
endinterface

// File: rtl/peak_regfile_mt.sv
// NTASK-context 32 x XLEN register file: two registered read ports, write-first bypass,
// single-cycle per-task clear, four-phase debug port. Optional parity: PEAK_REGFILE_PARITY_EN.
module peak_regfile_mt #(
   parameter int XLEN  = 32,
   parameter int NTASK = 2,
   parameter int TW    = $clog2(NTASK)
) (
   input logic              CLK,
   input logic              RST_N,
   peak_regfile_mt_if.slave bus
);
   localparam int NENT = NTASK * 32;
   localparam int IW   = TW + 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_WAIT = 2'd3;

   logic [XLEN-1:0] mem1_q [NENT];
   logic [XLEN-1:0] mem2_q [NENT];
   logic [NENT-1:0] vld_q, vld_d;
   logic [NENT-1:0] clr_mask_s, set_mask_s;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [XLEN-1:0] dbg_do_q, dbg_do_d;
   logic            dbg_ack_q, dbg_ack_d;
   logic            dbg_stall_q, dbg_stall_d;

   logic            acc_s;
   logic            wr_en_s;
   logic [IW-1:0]   wr_idx_s;
   logic [XLEN-1:0] wr_data_s;
   logic [IW-1:0]   rd1_idx_s, rd2_idx_s;

   function automatic logic par_f(input logic [XLEN-1:0] d);
      return ^d;
   endfunction

   // Write-first read resolution: r0, then same-cycle write, then same-cycle clear, then valid bit.
   function automatic logic [XLEN-1:0] rd_f(
      input logic [IW-1:0]   idx,
      input logic [XLEN-1:0] stored,
      input logic            vld,
      input logic            wen,
      input logic [IW-1:0]   widx,
      input logic [XLEN-1:0] wdata,
      input logic            clr,
      input logic [TW-1:0]   ctask
   );
      logic [XLEN-1:0] r;
      if (idx[4:0] == 5'd0) begin
         r = {XLEN{1'b0}};
      end else if (wen && (widx == idx)) begin
         r = wdata;
      end else if (clr && (idx[IW-1:5] == ctask)) begin
         r = {XLEN{1'b0}};
      end else if (vld) begin
         r = stored;
      end else begin
         r = {XLEN{1'b0}};
      end
      return r;
   endfunction

   // The debug access cycle owns the write port and read port 1; core WE is dropped.
   always_comb begin
      acc_s     = (state_q == ST_ACC);
      rd2_idx_s = {bus.RTASKNUM, bus.RS2ADDR};
      if (acc_s) begin
         wr_en_s   = bus.DBG_WR;
         wr_idx_s  = {bus.DBG_TASK, bus.DBG_AD};
         wr_data_s = bus.DBG_DI;
         rd1_idx_s = {bus.DBG_TASK, bus.DBG_AD};
      end else begin
         wr_en_s   = bus.WE;
         wr_idx_s  = {bus.WTASKNUM, bus.WADDR};
         wr_data_s = bus.WDATA;
         rd1_idx_s = {bus.RTASKNUM, bus.RS1ADDR};
      end
   end

   always_comb begin
      clr_mask_s = bus.CLR_REQ ?
                   ({{(NENT-32){1'b0}}, {32{1'b1}}} << {bus.CLR_TASK, 5'd0}) : {NENT{1'b0}};
      set_mask_s = wr_en_s ? ({{(NENT-1){1'b0}}, 1'b1} << wr_idx_s) : {NENT{1'b0}};
      vld_d      = (vld_q & ~clr_mask_s) | set_mask_s;
      rs1_d      = rd_f(rd1_idx_s, mem1_q[rd1_idx_s], vld_q[rd1_idx_s],
                        wr_en_s, wr_idx_s, wr_data_s, bus.CLR_REQ, bus.CLR_TASK);
      rs2_d      = rd_f(rd2_idx_s, mem2_q[rd2_idx_s], vld_q[rd2_idx_s],
                        wr_en_s, wr_idx_s, wr_data_s, bus.CLR_REQ, bus.CLR_TASK);
   end

   // Stall/ack are decoded from the next state so they are registered yet aligned with it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.DBG_REQ) state_d = ST_ACC;
            else             state_d = ST_IDLE;
         end
         ST_ACC:  state_d = ST_RESP;
         ST_RESP: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!bus.DBG_REQ) state_d = ST_IDLE;
            else              state_d = ST_WAIT;
         end
         default: state_d = ST_IDLE;
      endcase
      dbg_stall_d = (state_d == ST_ACC) || (state_d == ST_RESP);
      dbg_ack_d   = (state_d == ST_RESP) || (state_d == ST_WAIT);
      if (state_d == ST_RESP) dbg_do_d = rs1_d;
      else                    dbg_do_d = dbg_do_q;
   end

   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         mem1_q[wr_idx_s] <= wr_data_s;
         mem2_q[wr_idx_s] <= wr_data_s;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_q       <= {NENT{1'b0}};
         state_q     <= ST_IDLE;
         rs1_q       <= {XLEN{1'b0}};
         rs2_q       <= {XLEN{1'b0}};
         dbg_do_q    <= {XLEN{1'b0}};
         dbg_ack_q   <= 1'b0;
         dbg_stall_q <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         state_q     <= state_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         dbg_do_q    <= dbg_do_d;
         dbg_ack_q   <= dbg_ack_d;
         dbg_stall_q <= dbg_stall_d;
      end
   end

   assign bus.RS1       = rs1_q;
   assign bus.RS2       = rs2_q;
   assign bus.DBG_DO    = dbg_do_q;
   assign bus.DBG_ACK   = dbg_ack_q;
   assign bus.DBG_STALL = dbg_stall_q;

`ifdef PEAK_REGFILE_PARITY_EN
   logic [NENT-1:0] par1_q, par2_q;
   logic            perr_q, perr_d;

   // Only entries that would actually be read from storage are checked.
   function automatic logic chk_f(
      input logic [IW-1:0]   idx,
      input logic [XLEN-1:0] stored,
      input logic            par,
      input logic            vld,
      input logic            wen,
      input logic [IW-1:0]   widx,
      input logic            clr,
      input logic [TW-1:0]   ctask
   );
      logic e;
      if (idx[4:0] == 5'd0) begin
         e = 1'b0;
      end else if (wen && (widx == idx)) begin
         e = 1'b0;
      end else if (clr && (idx[IW-1:5] == ctask)) begin
         e = 1'b0;
      end else if (vld) begin
         e = (par_f(stored) != par);
      end else begin
         e = 1'b0;
      end
      return e;
   endfunction

   always_comb begin
      perr_d = chk_f(rd1_idx_s, mem1_q[rd1_idx_s], par1_q[rd1_idx_s], vld_q[rd1_idx_s],
                     wr_en_s, wr_idx_s, bus.CLR_REQ, bus.CLR_TASK)
             | chk_f(rd2_idx_s, mem2_q[rd2_idx_s], par2_q[rd2_idx_s], vld_q[rd2_idx_s],
                     wr_en_s, wr_idx_s, bus.CLR_REQ, bus.CLR_TASK);
   end

   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         par1_q[wr_idx_s] <= par_f(wr_data_s);
         par2_q[wr_idx_s] <= par_f(wr_data_s);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) perr_q <= 1'b0;
      else        perr_q <= perr_d;
   end

   assign bus.PERR = perr_q;
`else
   assign bus.PERR = 1'b0;
`endif

endmodule
